ps_data_filter: RTL and testbench

- Upstream conditioning stage for the proximity-sensor level comparator.
- Accepts raw 18-bit proximity samples from the sensor reader as single-cycle valid strobes.
- Keeps a 2^LOG2_N-deep boxcar moving average and presents the registered mean as PS_DATA, the input of the level comparator.
- Flags when the window is filled and when the sensor has stopped delivering samples.

---
 rtl/ps_data_filter.sv | 201 ++++++++++++++++++++
 tb/tb_ps_data_filter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps_data_filter.sv
// Boxcar moving-average filter conditioning raw proximity samples for the level comparator.
// Defining PS_FILT_SPIKE_REJECT_EN adds spike rejection of outlier samples while in RUN.

module ps_data_filter #(
  parameter int            DW          = 18,
  parameter int            LOG2_N      = 3,
  parameter int            TIMEOUT_CYC = 50000000,
  parameter logic [DW-1:0] SPIKE_TH    = 18'h01000,
  parameter int            SPIKE_MAX   = 3
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic [DW-1:0] SAMPLE_IN,
  input  logic          SAMPLE_VLD,
  input  logic          CLR,
  output logic [DW-1:0] PS_DATA,
  output logic          PS_VLD,
  output logic          PS_READY,
  output logic          STALE
);

  localparam int               N         = 1 << LOG2_N;
  localparam int               SW        = DW + LOG2_N;
  localparam int               TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]    TO_MAX    = TW'(TIMEOUT_CYC);
  localparam logic [LOG2_N:0]  FILL_LAST = (LOG2_N + 1)'(N - 1);
  localparam logic [DW-1:0]    FAR_VAL   = {DW{1'b1}};

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [LOG2_N-1:0] wr_q, wr_d;
  logic [LOG2_N:0]   fill_q, fill_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic [DW-1:0]     buf_q [N];
  logic              pub_q, pub_d;
  logic [DW-1:0]     ps_data_q, ps_data_d;
  logic              ps_vld_q, ps_vld_d;
  logic              ps_ready_q, ps_ready_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic              stale_q, stale_d;
  logic              accept_s;
  logic [DW-1:0]     evict_s;

`ifdef PS_FILT_SPIKE_REJECT_EN
  localparam int            RW      = $clog2(SPIKE_MAX + 1);
  localparam logic [RW-1:0] REJ_MAX = RW'(SPIKE_MAX);

  logic [RW-1:0] rej_q, rej_d;
  logic [DW-1:0] diff_s;
  logic          spike_s;

  // Outlier detection against the published mean; forced acceptance after SPIKE_MAX rejects
  always_comb begin
    diff_s   = (SAMPLE_IN >= ps_data_q) ? (SAMPLE_IN - ps_data_q) : (ps_data_q - SAMPLE_IN);
    spike_s  = (state_q == S_RUN) && (diff_s > SPIKE_TH) && (rej_q != REJ_MAX);
    accept_s = SAMPLE_VLD && !CLR && !spike_s;
    if (CLR) begin
      rej_d = '0;
    end else if (accept_s) begin
      rej_d = '0;
    end else if (SAMPLE_VLD) begin
      rej_d = rej_q + RW'(1);
    end else begin
      rej_d = rej_q;
    end
  end

  // Consecutive-reject counter
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rej_q <= '0;
    end else begin
      rej_q <= rej_d;
    end
  end
`else
  // Every strobe is taken unless a flush coincides with it
  always_comb begin
    accept_s = SAMPLE_VLD && !CLR;
  end
`endif

  // Oldest term leaving the window; zero while filling so stale buffer contents never matter
  always_comb begin
    evict_s = (state_q == S_RUN) ? buf_q[wr_q] : '0;
  end

  // Window bookkeeping, fill/run sequencing and output publication
  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    fill_d     = fill_q;
    sum_d      = sum_q;
    pub_d      = 1'b0;
    ps_data_d  = ps_data_q;
    ps_vld_d   = 1'b0;
    ps_ready_d = ps_ready_q;
    if (CLR) begin
      state_d    = S_FILL;
      wr_d       = '0;
      fill_d     = '0;
      sum_d      = '0;
      ps_data_d  = FAR_VAL;
      ps_ready_d = 1'b0;
    end else begin
      ps_vld_d = pub_q;
      if (pub_q) begin
        ps_data_d  = sum_q[SW-1:LOG2_N];
        ps_ready_d = 1'b1;
      end else begin
        ps_data_d  = ps_data_q;
        ps_ready_d = ps_ready_q;
      end
      if (accept_s) begin
        // The evicted term is already part of the sum, so this cannot underflow
        sum_d = sum_q + SW'(SAMPLE_IN) - SW'(evict_s);
        wr_d  = wr_q + LOG2_N'(1);
        case (state_q)
          S_FILL: begin
            fill_d = fill_q + (LOG2_N + 1)'(1);
            if (fill_q == FILL_LAST) begin
              state_d = S_RUN;
              pub_d   = 1'b1;
            end else begin
              state_d = S_FILL;
              pub_d   = 1'b0;
            end
          end
          S_RUN: begin
            pub_d = 1'b1;
          end
          default: begin
            state_d = S_FILL;
          end
        endcase
      end else begin
        sum_d = sum_q;
      end
    end
  end

  // Saturating idle counter behind STALE
  always_comb begin
    if (SAMPLE_VLD) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_MAX) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end
    stale_d = (to_cnt_d == TO_MAX);
  end

  // Main state and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_FILL;
      wr_q       <= '0;
      fill_q     <= '0;
      sum_q      <= '0;
      pub_q      <= 1'b0;
      ps_data_q  <= FAR_VAL;
      ps_vld_q   <= 1'b0;
      ps_ready_q <= 1'b0;
      to_cnt_q   <= '0;
      stale_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_q       <= wr_d;
      fill_q     <= fill_d;
      sum_q      <= sum_d;
      pub_q      <= pub_d;
      ps_data_q  <= ps_data_d;
      ps_vld_q   <= ps_vld_d;
      ps_ready_q <= ps_ready_d;
      to_cnt_q   <= to_cnt_d;
      stale_q    <= stale_d;
    end
  end

  // Sample ring buffer
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < N; i++) begin
        buf_q[i] <= '0;
      end
    end else if (accept_s) begin
      buf_q[wr_q] <= SAMPLE_IN;
    end
  end

  assign PS_DATA  = ps_data_q;
  assign PS_VLD   = ps_vld_q;
  assign PS_READY = ps_ready_q;
  assign STALE    = stale_q;

endmodule

// File: tb/tb_ps_data_filter.sv
// Self-checking bench for ps_data_filter: directed scenarios plus random traffic
// compared every cycle against a queue-based window model.

module tb_ps_data_filter;

  localparam int            DW     = 18;
  localparam int            LOG2_N = 3;
  localparam int            N      = 8;
  localparam int            TO     = 100;
  localparam logic [DW-1:0] FAR    = 18'h3FFFF;
`ifdef PS_FILT_SPIKE_REJECT_EN
  localparam logic [DW-1:0] SPIKE_TH  = 18'h01000;
  localparam int            SPIKE_MAX = 3;
  localparam logic [DW-1:0] EXP6      = 18'h040E0;
`else
  localparam logic [DW-1:0] EXP6      = 18'h10080;
`endif

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [DW-1:0] SAMPLE_IN;
  logic          SAMPLE_VLD;
  logic          CLR;
  logic [DW-1:0] PS_DATA;
  logic          PS_VLD;
  logic          PS_READY;
  logic          STALE;

  int checks   = 0;
  int failures = 0;
  int vld_seen = 0;

  int unsigned   win[$];
  bit            p_vld;
  logic [DW-1:0] p_val;
  logic [DW-1:0] exp_data;
  bit            exp_vld;
  bit            exp_ready;
  bit            exp_stale;
  int            idle;
  int            rej;

  ps_data_filter #(
    .DW(DW), .LOG2_N(LOG2_N), .TIMEOUT_CYC(TO)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .SAMPLE_IN(SAMPLE_IN), .SAMPLE_VLD(SAMPLE_VLD),
    .CLR(CLR), .PS_DATA(PS_DATA), .PS_VLD(PS_VLD), .PS_READY(PS_READY), .STALE(STALE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] window_mean();
    longint s = 0;
    foreach (win[i]) s += longint'(win[i]);
    return DW'(s / N);
  endfunction

`ifdef PS_FILT_SPIKE_REJECT_EN
  function automatic int absdiff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a >= b) ? int'(a - b) : int'(b - a);
  endfunction
`endif

  task automatic model_reset();
    win.delete();
    p_vld = 1'b0; p_val = '0; exp_data = FAR; exp_vld = 1'b0;
    exp_ready = 1'b0; exp_stale = 1'b0; idle = 0; rej = 0;
  endtask

  // One clock edge of the reference: window of the last N accepted samples, mean shown 2 cycles later
  task automatic model_step(input bit v, input logic [DW-1:0] d, input bit c);
    bit accept;
`ifdef PS_FILT_SPIKE_REJECT_EN
    logic [DW-1:0] cur_data = exp_data;
`endif
    if (c) begin
      win.delete();
      p_vld = 1'b0; exp_vld = 1'b0; exp_data = FAR; exp_ready = 1'b0; rej = 0;
    end else begin
      exp_vld = p_vld;
      if (p_vld) begin
        exp_data  = p_val;
        exp_ready = 1'b1;
      end
      p_vld = 1'b0;
      if (v) begin
        accept = 1'b1;
`ifdef PS_FILT_SPIKE_REJECT_EN
        if (win.size() == N && absdiff(d, cur_data) > int'(SPIKE_TH) && rej < SPIKE_MAX) accept = 1'b0;
`endif
        if (accept) begin
          win.push_back(32'(d));
          if (win.size() > N) void'(win.pop_front());
          if (win.size() == N) begin
            p_vld = 1'b1;
            p_val = window_mean();
          end
          rej = 0;
        end else begin
          rej++;
        end
      end
    end
    if (v) idle = 0;
    else if (idle < TO) idle++;
    exp_stale = (idle == TO);
  endtask

  task automatic compare_all();
    check("ps_data", 32'(PS_DATA), 32'(exp_data));
    check("ps_vld", 32'(PS_VLD), 32'(exp_vld));
    check("ps_ready", 32'(PS_READY), 32'(exp_ready));
    check("stale", 32'(STALE), 32'(exp_stale));
  endtask

  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit c);
    SAMPLE_VLD = v; SAMPLE_IN = d; CLR = c;
    @(posedge CLK);
    model_step(v, d, c);
    #1;
    compare_all();
    if (PS_VLD) vld_seen++;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"}, 32'(PS_DATA), 32'(FAR));
    check({tag, "_vld"}, 32'(PS_VLD), 32'd0);
    check({tag, "_ready"}, 32'(PS_READY), 32'd0);
    check({tag, "_stale"}, 32'(STALE), 32'd0);
  endtask

  initial begin
    RESET_N = 1'b0; SAMPLE_VLD = 1'b0; SAMPLE_IN = '0; CLR = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_reset_vals("por");
    RESET_N = 1'b1;

    // Reset mid-stream, with a publish still in flight
    repeat (9) cycle(1'b1, 18'h00555, 1'b0);
    RESET_N = 1'b0; SAMPLE_VLD = 1'b0;
    #1;
    model_reset();
    check_reset_vals("arst");
    @(posedge CLK); #1;
    check_reset_vals("arst_hold");
    RESET_N = 1'b1;

    // Fill with 0x100
    vld_seen = 0;
    repeat (7) cycle(1'b1, 18'h00100, 1'b0);
    check("t2_no_early", 32'(vld_seen), 32'd0);
    cycle(1'b1, 18'h00100, 1'b0);
    check("t2_vld_lat1", 32'(PS_VLD), 32'd0);
    cycle(1'b0, 18'h00000, 1'b0);
    check("t2_vld", 32'(PS_VLD), 32'd1);
    check("t2_data", 32'(PS_DATA), 32'h00100);
    check("t2_ready", 32'(PS_READY), 32'd1);

    // Back-to-back 0x900 across a full pointer wrap
    vld_seen = 0;
    cycle(1'b1, 18'h00900, 1'b0);
    cycle(1'b1, 18'h00900, 1'b0);
    check("t3_first", 32'(PS_DATA), 32'h00200);
    repeat (6) cycle(1'b1, 18'h00900, 1'b0);
    cycle(1'b0, 18'h00000, 1'b0);
    check("t3_last", 32'(PS_DATA), 32'h00900);
    check("t3_pulses", 32'(vld_seen), 32'd8);

    // Full-scale samples, then flush with a coincident strobe
    cycle(1'b0, 18'h00000, 1'b1);
    repeat (8) cycle(1'b1, 18'h3FFFF, 1'b0);
    cycle(1'b0, 18'h00000, 1'b0);
    check("t4_fill_data", 32'(PS_DATA), 32'h3FFFF);
    repeat (8) cycle(1'b1, 18'h3FFFF, 1'b0);
    cycle(1'b0, 18'h00000, 1'b0);
    check("t4_run_data", 32'(PS_DATA), 32'h3FFFF);
    cycle(1'b1, 18'h3FFFF, 1'b0);
    cycle(1'b1, 18'h00005, 1'b1);
    check("t4_clr_ready", 32'(PS_READY), 32'd0);
    check("t4_clr_data", 32'(PS_DATA), 32'h3FFFF);
    check("t4_clr_vld", 32'(PS_VLD), 32'd0);
    vld_seen = 0;
    repeat (7) cycle(1'b1, 18'h00040, 1'b0);
    repeat (2) cycle(1'b0, 18'h00000, 1'b0);
    check("t4_dropped", 32'(vld_seen), 32'd0);
    cycle(1'b1, 18'h00040, 1'b0);
    cycle(1'b0, 18'h00000, 1'b0);
    check("t4_refill", 32'(PS_DATA), 32'h00040);

    // Spike burst on a settled 0x100 window
    cycle(1'b0, 18'h00000, 1'b1);
    repeat (8) cycle(1'b1, 18'h00100, 1'b0);
    repeat (2) cycle(1'b0, 18'h00000, 1'b0);
    repeat (4) cycle(1'b1, 18'h20000, 1'b0);
    cycle(1'b0, 18'h00000, 1'b0);
    check("t6_data", 32'(PS_DATA), 32'(EXP6));

    // Timeout: idle count is 1 here
    repeat (98) cycle(1'b0, 18'h00000, 1'b0);
    check("t5_pre", 32'(STALE), 32'd0);
    cycle(1'b0, 18'h00000, 1'b0);
    check("t5_stale", 32'(STALE), 32'd1);
    cycle(1'b0, 18'h00000, 1'b0);
    check("t5_sat", 32'(STALE), 32'd1);
    cycle(1'b1, 18'h00100, 1'b0);
    check("t5_clear", 32'(STALE), 32'd0);
    check("t5_hold", 32'(PS_DATA), 32'(EXP6));

    // Random traffic with occasional flushes and one asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      logic [DW-1:0] d;
      bit v, c;
      if (i == 750) begin
        RESET_N = 1'b0; SAMPLE_VLD = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge CLK); #1;
        RESET_N = 1'b1;
      end
      v = ($urandom_range(0, 99) < 60);
      c = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) d = DW'($urandom);
      else d = 18'h08000 + DW'($urandom_range(0, 4095));
      cycle(v, d, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
